// File: rtl/num_char.sv
// ---------------------------------------------------------------------------
// num_char -- MIX NUM / CHAR conversion unit (C=5, F=0 / F=1)
//
// Works on the rA:rX byte pair beside the shift unit and uses the same
// start/field/ina/inx -> outa/outx/stop handshake. Magnitudes only; the
// caller owns the signs.
//
//   NUM  : ten character bytes (rA byte1..byte5, then rX byte1..byte5) are
//          folded into a binary value, one byte per cycle (10 cycles):
//          acc = acc*10 + (byte mod 10). outa = acc mod 2^30, outx = rX,
//          ovf = (acc >= 2^30).
//   CHAR : rA is converted to ten decimal digits by double-dabble, one bit
//          per cycle (30 cycles). Digit d becomes byte ZERO_CODE+d; the
//          upper five digits go to outa, the lower five to outx.
//   other F values pass ina/inx straight through in a single cycle.
//
// Ports
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous active-high reset (aborts any operation)
//   start  in   1  request; accepted only in IDLE or DONE
//   field  in   6  F field (0 = NUM, 1 = CHAR, else pass-through)
//   ina    in  30  rA magnitude, byte1 = [29:24] .. byte5 = [5:0]
//   inx    in  30  rX magnitude, same byte order
//   outa   out 30  new rA magnitude (updates only on entry to DONE)
//   outx   out 30  new rX magnitude (updates only on entry to DONE)
//   stop   out  1  one-cycle completion pulse
//   busy   out  1  high in NUM, CHAR and DONE
//   ovf    out  1  NUM overflow, held until the next accepted start
// ---------------------------------------------------------------------------
module num_char #(
  parameter int ZERO_CODE = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  field,
  input  logic [29:0] ina,
  input  logic [29:0] inx,
  output logic [29:0] outa,
  output logic [29:0] outx,
  output logic        stop,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE,
    NUM,
    CHAR,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [59:0] sh_q, sh_d;      // byte/bit stream, consumed from the top
  logic [29:0] x_q, x_d;        // latched rX, returned unchanged by NUM
  logic [33:0] acc_q, acc_d;    // NUM accumulator, holds up to 9999999999
  logic [39:0] bcd_q, bcd_d;    // CHAR BCD register, ten digits
  logic [4:0]  cnt_q, cnt_d;
  logic [29:0] outa_q, outa_d;
  logic [29:0] outx_q, outx_d;
  logic        ovf_q, ovf_d;

  logic [33:0] acc_next;
  logic [39:0] bcd_adj;
  logic [39:0] bcd_next;

  // Residue of a 6-bit character code modulo 10.
  function automatic logic [3:0] mod10(input logic [5:0] v);
    logic [5:0] r;
    if      (v >= 6'd60) r = v - 6'd60;
    else if (v >= 6'd50) r = v - 6'd50;
    else if (v >= 6'd40) r = v - 6'd40;
    else if (v >= 6'd30) r = v - 6'd30;
    else if (v >= 6'd20) r = v - 6'd20;
    else if (v >= 6'd10) r = v - 6'd10;
    else                 r = v;
    return r[3:0];
  endfunction

  function automatic logic [5:0] to_code(input logic [3:0] d);
    return 6'(ZERO_CODE) + {2'b00, d};
  endfunction

  // Datapath step values, shared by the state logic below.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned -- that is what keeps latches from being inferred.
    bcd_adj  = bcd_q;
    acc_next = (acc_q << 3) + (acc_q << 1) + {30'd0, mod10(sh_q[59:54])};
    // Double-dabble correction: any digit >= 5 would carry after the shift.
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[38:0], sh_q[59]};
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    x_d     = x_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    outa_d  = outa_q;
    outx_d  = outx_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sh_d  = {ina, inx};
          x_d   = inx;
          acc_d = '0;
          bcd_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          if (field == 6'd0) begin
            state_d = NUM;
          end else if (field == 6'd1) begin
            state_d = CHAR;
          end else begin
            state_d = DONE;
            outa_d  = ina;
            outx_d  = inx;
          end
        end else begin
          state_d = IDLE;
        end
      end

      NUM: begin
        acc_d = acc_next;
        sh_d  = sh_q << 6;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd9) begin
          state_d = DONE;
          outa_d  = acc_next[29:0];
          outx_d  = x_q;
          ovf_d   = |acc_next[33:30];
        end
      end

      CHAR: begin
        bcd_d = bcd_next;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd29) begin
          state_d = DONE;
          ovf_d   = 1'b0;
          // Digit d(i+5) lands in outa, d(i) in outx; byte5 holds the lowest.
          for (int i = 0; i < 5; i++) begin
            outa_d[6*i +: 6] = to_code(bcd_next[4*(i+5) +: 4]);
            outx_d[6*i +: 6] = to_code(bcd_next[4*i +: 4]);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      outa_q  <= '0;
      outx_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      outa_q  <= outa_d;
      outx_q  <= outx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign outa = outa_q;
  assign outx = outx_q;
  assign ovf  = ovf_q;
  assign stop = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_num_char.sv
// ---------------------------------------------------------------------------
// tb_num_char -- self-checking bench for num_char.
// Directed vector table, hand-written protocol/reset sequences, then random
// operations checked against a decimal-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_num_char;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  field;
  logic [29:0] ina;
  logic [29:0] inx;
  logic [29:0] outa;
  logic [29:0] outx;
  logic        stop;
  logic        busy;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  num_char #(.ZERO_CODE(30)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .field (field),
    .ina   (ina),
    .inx   (inx),
    .outa  (outa),
    .outx  (outx),
    .stop  (stop),
    .busy  (busy),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [29:0] a;
    logic [29:0] x;
    logic [29:0] ea;
    logic [29:0] ex;
    logic        eo;
    int          lat;
  } vec_t;

  vec_t vec [7];

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [29:0] pack(input int b1, input int b2, input int b3,
                                       input int b4, input int b5);
    return {6'(b1), 6'(b2), 6'(b3), 6'(b4), 6'(b5)};
  endfunction

  // Reference NUM: decimal value of the ten byte residues.
  function automatic void num_model(input logic [29:0] a, input logic [29:0] x,
                                    output logic [29:0] ra, output logic ro);
    longint v = 0;
    int b;
    for (int i = 0; i < 10; i++) begin
      b = (i < 5) ? int'(a[(29 - 6*i) -: 6]) : int'(x[(29 - 6*(i-5)) -: 6]);
      v = v * 10 + (b % 10);
    end
    ra = 30'(v % (64'd1 << 30));
    ro = (v >= (64'd1 << 30));
  endfunction

  // Reference CHAR: ten decimal digits of a as character codes.
  function automatic void char_model(input logic [29:0] a,
                                     output logic [29:0] ra, output logic [29:0] rx);
    longint n = longint'(a);
    int d [10];
    for (int i = 0; i < 10; i++) begin
      d[i] = int'(n % 10);
      n = n / 10;
    end
    ra = pack(30+d[9], 30+d[8], 30+d[7], 30+d[6], 30+d[5]);
    rx = pack(30+d[4], 30+d[3], 30+d[2], 30+d[1], 30+d[0]);
  endfunction

  // Called at a negedge; returns at the negedge of cycle T+1.
  task automatic issue(input logic [5:0] f, input logic [29:0] a, input logic [29:0] x);
    start = 1'b1;
    field = f;
    ina   = a;
    inx   = x;
    @(negedge clk);
    start = 1'b0;
    ina   = $urandom();
    inx   = $urandom();
  endtask

  // Count cycles (starting at k0) until stop is seen; lat=0 on timeout.
  task automatic wait_stop(input int k0, output int lat);
    lat = 0;
    for (int k = k0; k < 60; k++) begin
      if (stop) begin
        lat = k;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [5:0] f,
                        input logic [29:0] a, input logic [29:0] x,
                        input logic [29:0] ea, input logic [29:0] ex,
                        input logic eo, input int elat);
    int lat;
    issue(f, a, x);
    wait_stop(1, lat);
    check({name, " latency"}, lat, elat);
    check({name, " outa"}, outa, ea);
    check({name, " outx"}, outx, ex);
    check({name, " ovf"}, ovf, eo);
    check({name, " busy@stop"}, busy, 1);
    @(negedge clk);
    check({name, " stop width"}, stop, 0);
    check({name, " busy idle"}, busy, 0);
    check({name, " outa held"}, outa, ea);
    check({name, " ovf held"}, ovf, eo);
  endtask

  initial begin
    logic [29:0] ka, kx, ra, rx;
    logic        ro;
    logic [5:0]  f;
    int          lat;
    int          seen;

    rst = 1'b1; start = 1'b0; field = '0; ina = '0; inx = '0;
    repeat (2) @(negedge clk);
    check("reset outa", outa, 0);
    check("reset outx", outx, 0);
    check("reset stop", stop, 0);
    check("reset busy", busy, 0);
    check("reset ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    ka = pack(0, 0, 31, 32, 39);
    kx = pack(37, 57, 47, 30, 30);
    vec[0] = '{6'd0, ka, kx, 30'd12977700, kx, 1'b0, 11};
    vec[1] = '{6'd1, 30'd12977699, 30'h155, pack(30,30,31,32,39), pack(37,37,36,39,39), 1'b0, 31};
    vec[2] = '{6'd1, 30'd0, 30'h3FFFFFFF, pack(30,30,30,30,30), pack(30,30,30,30,30), 1'b0, 31};
    vec[3] = '{6'd1, 30'd1073741823, 30'd0, pack(31,30,37,33,37), pack(34,31,38,32,33), 1'b0, 31};
    vec[4] = '{6'd0, pack(39,39,39,39,39), pack(39,39,39,39,39), 30'd336323583, pack(39,39,39,39,39), 1'b1, 11};
    vec[5] = '{6'd0, pack(30,30,30,30,30), pack(30,30,30,30,30), 30'd0, pack(30,30,30,30,30), 1'b0, 11};
    vec[6] = '{6'd7, 30'h1234567, 30'h3ABCDEF, 30'h1234567, 30'h3ABCDEF, 1'b0, 1};

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vec[i].f, vec[i].a, vec[i].x,
             vec[i].ea, vec[i].ex, vec[i].eo, vec[i].lat);
    end

    // Start during NUM is ignored; the Knuth result still arrives at T+11.
    issue(6'd0, ka, kx);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; field = 6'd1; ina = 30'd5; inx = 30'd5;
    @(negedge clk);
    start = 1'b0;
    wait_stop(4, lat);
    check("ignore latency", lat, 11);
    check("ignore outa", outa, 30'd12977700);
    check("ignore outx", outx, kx);
    @(negedge clk);
    check("ignore idle", busy, 0);

    // Back-to-back: start in the stop cycle begins a new CHAR.
    issue(6'd0, ka, kx);
    wait_stop(1, lat);
    check("b2b first latency", lat, 11);
    check("b2b first outa", outa, 30'd12977700);
    issue(6'd1, 30'd12977699, 30'd0);
    check("b2b busy", busy, 1);
    check("b2b stop dropped", stop, 0);
    wait_stop(1, lat);
    check("b2b second latency", lat, 31);
    check("b2b second outa", outa, pack(30,30,31,32,39));
    check("b2b second outx", outx, pack(37,37,36,39,39));
    @(negedge clk);

    // Reset at T+5 of a CHAR aborts it with no stop pulse.
    issue(6'd1, 30'd987654321, 30'd0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort outa", outa, 0);
    check("abort outx", outx, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (stop) seen++;
      @(negedge clk);
    end
    check("abort no stop", seen, 0);
    char_model(30'd987654321, ra, rx);
    run_op("after abort", 6'd1, 30'd987654321, 30'd0, ra, rx, 1'b0, 31);

    // Random operations against the model.
    for (int i = 0; i < 24; i++) begin
      logic [29:0] a, x;
      a = 30'($urandom());
      x = 30'($urandom());
      case ($urandom_range(0, 2))
        0: f = 6'd0;
        1: f = 6'd1;
        default: f = 6'($urandom_range(2, 63));
      endcase
      if (f == 6'd0) begin
        num_model(a, x, ra, ro);
        run_op($sformatf("rnd%0d num", i), f, a, x, ra, x, ro, 11);
      end else if (f == 6'd1) begin
        char_model(a, ra, rx);
        run_op($sformatf("rnd%0d char", i), f, a, x, ra, rx, 1'b0, 31);
      end else begin
        run_op($sformatf("rnd%0d pass", i), f, a, x, a, x, 1'b0, 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/num_char.md
Name: num_char

Overview:
- Multi-cycle conversion unit for the MIX special instructions NUM (C=5, F=0) and CHAR (C=5, F=1). Operates on the rA:rX 60-bit byte pair, like the shift unit.
- NUM packs ten character-code bytes into a binary rA magnitude. CHAR unpacks a binary rA magnitude into ten character codes.
- Sits beside the shift unit in the execute stage with the same start/field/ina/inx/outa/outx/stop contract. Signs are handled by the caller.

Parameters:
- ZERO_CODE, 30: MIX character code of digit 0. Digit d maps to ZERO_CODE+d.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request; samples field, ina and inx.
- field, input, 6: F field. 0 selects NUM, 1 selects CHAR.
- ina, input, 30: rA magnitude. Byte1 is [29:24], byte5 is [5:0].
- inx, input, 30: rX magnitude, same byte order.
- outa, output, 30: new rA magnitude.
- outx, output, 30: new rX magnitude.
- stop, output, 1: one-cycle done pulse.
- busy, output, 1: high from the cycle after start until the stop cycle, inclusive.
- ovf, output, 1: NUM overflow. Valid in the stop cycle and held until the next accepted start.

Behaviour:
- States: IDLE, NUM, CHAR, DONE.
- Reset: state IDLE; outa=0, outx=0, stop=0, busy=0, ovf=0. Reset mid-operation aborts the operation and produces no stop pulse.
- Acceptance: start is accepted only in IDLE or DONE. Start while in NUM or CHAR is ignored.
- Accepted start in cycle T: ina and inx are latched at the end of cycle T, ovf clears, and iteration counter cnt=0.
  - field=0: next state NUM.
  - field=1: next state CHAR.
  - any other field: next state DONE, with outa=ina and outx=inx (pass-through). stop is high in cycle T+1.
- NUM operation:
  - Byte stream order: ina byte1..byte5, then inx byte1..byte5.
  - One byte per cycle for 10 cycles (T+1..T+10): acc <= acc*10 + (byte mod 10).
  - acc is 34 bits wide, which covers 9999999999.
  - byte mod 10 is computed combinationally for 0..63.
  - When cnt=9 completes:
    - outa = acc[29:0], i.e. the result modulo 2^30.
    - outx = latched inx, unchanged.
    - ovf = (final acc >= 2^30).
  - DONE is entered with stop=1 in cycle T+11.
- CHAR operation:
  - Double-dabble over the 30-bit latched ina, one bit per cycle for 30 cycles (T+1..T+30), MSB first.
  - Each cycle, before the shift, add 3 to every 4-bit BCD digit that is >= 5, across a 40-bit BCD register (10 digits).
  - When cnt=29 completes:
    - Digits d9..d0 become bytes ZERO_CODE+d.
    - outa = d9..d5 (d9 in byte1).
    - outx = d4..d0.
    - ovf = 0.
  - stop=1 in cycle T+31.
- Output timing:
  - outa and outx are registered.
  - They change only on the edge that enters DONE and hold their value until the next DONE entry or reset.
  - Intermediate values never appear on outa or outx.
- DONE behaviour:
  - stop is high for exactly one cycle.
  - The following cycle the state returns to IDLE unless a start is present in DONE. Such a start is accepted as in IDLE, giving back-to-back operation.
- busy: low in IDLE; high in NUM, CHAR and DONE.

Test Plan:
- NUM, Knuth example: ina bytes 00,00,31,32,39 and inx bytes 37,57,47,30,30 -> stop at T+11; outa=12977700; outx unchanged; ovf=0.
- CHAR: ina=12977699 -> stop at T+31; outa bytes 30,30,31,32,39; outx bytes 37,37,36,39,39; ovf=0.
- CHAR boundaries:
  - ina=0 -> all ten bytes equal 30.
  - ina=1073741823 -> outa bytes 31,30,37,33,37; outx bytes 34,31,38,32,33.
- NUM overflow: all ten bytes 39 -> outa=336323583, ovf=1. Then NUM of all bytes 30 -> outa=0, ovf=0.
- Protocol:
  - Start during NUM is ignored, and the original result is produced.
  - field=7 -> stop at T+1 with outa=ina and outx=inx.
  - Start coincident with the stop cycle begins a new operation.
- Reset: assert rst at T+5 of a CHAR operation -> no stop pulse; outa=outx=0; busy=0. A new start then completes normally.
